// File: rtl/mc_ctrl_fsm_if.sv
// mc_ctrl_fsm_if: control bundle between the multicycle controller and its datapath
interface mc_ctrl_fsm_if #(parameter int STATE_W = 4);
    logic [5:0]         opcode;
    logic               zero;
    logic               mem_ready;
    logic               pc_write;
    logic               pc_write_cond;
    logic               i_or_d;
    logic               mem_read;
    logic               mem_write;
    logic               ir_write;
    logic               mem_to_reg;
    logic               reg_dst;
    logic               reg_write;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic [1:0]         alu_op;
    logic [1:0]         pc_source;
    logic               instr_done;
    logic               illegal_op;
    logic [STATE_W-1:0] state;
    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, instr_done, illegal_op, state
    );
    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, instr_done, illegal_op, state
    );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multicycle MIPS-subset controller sequencing fetch/decode/execute/mem/writeback
module mc_ctrl_fsm #(parameter int STATE_W = 4) (
    input logic          clk,
    input logic          rst_n,
    mc_ctrl_fsm_if.master bus
);
    typedef enum logic [3:0] {
        INIT   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        MEMADR = 4'd3,
        MEMRD  = 4'd4,
        MEMWB  = 4'd5,
        MEMWR  = 4'd6,
        EXEC   = 4'd7,
        RWB    = 4'd8,
        BEQ    = 4'd9,
        JUMP   = 4'd10,
        ADDIEX = 4'd11,
        ADDIWB = 4'd12
    } state_t;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    state_t st;
    logic   legal;
    logic   unused_zero;
    // the zero flag gates the branch PC load inside the datapath, not here
    assign unused_zero = bus.zero;
    assign legal = bus.opcode inside {OP_LW, OP_SW, OP_R, OP_BEQ, OP_J, OP_ADDI};
    assign bus.state = STATE_W'(st);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            st <= INIT;
        else
            case (st)
                INIT:   st <= FETCH;
                FETCH:  st <= bus.mem_ready ? DECODE : FETCH;
                DECODE: st <= (bus.opcode == OP_LW || bus.opcode == OP_SW) ? MEMADR :
                              bus.opcode == OP_R    ? EXEC   :
                              bus.opcode == OP_BEQ  ? BEQ    :
                              bus.opcode == OP_J    ? JUMP   :
                              bus.opcode == OP_ADDI ? ADDIEX : FETCH;
                MEMADR: st <= bus.opcode == OP_LW ? MEMRD : MEMWR;
                MEMRD:  st <= bus.mem_ready ? MEMWB : MEMRD;
                MEMWR:  st <= bus.mem_ready ? FETCH : MEMWR;
                EXEC:   st <= RWB;
                ADDIEX: st <= ADDIWB;
                MEMWB, RWB, BEQ, JUMP, ADDIWB: st <= FETCH;
                default: st <= INIT;
            endcase
    always_comb begin
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.i_or_d        = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.reg_write     = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = 2'b00;
        bus.alu_op        = 2'b00;
        bus.pc_source     = 2'b00;
        bus.instr_done    = 1'b0;
        bus.illegal_op    = 1'b0;
        case (st)
            FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = 2'b01;
                bus.ir_write  = bus.mem_ready;
                bus.pc_write  = bus.mem_ready;
            end
            DECODE: begin
                bus.alu_src_b  = 2'b11;
                bus.illegal_op = !legal;
                bus.instr_done = !legal;
            end
            MEMADR, ADDIEX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
            end
            MEMRD: begin
                bus.mem_read = 1'b1;
                bus.i_or_d   = 1'b1;
            end
            MEMWB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
                bus.instr_done = 1'b1;
            end
            MEMWR: begin
                bus.mem_write  = 1'b1;
                bus.i_or_d     = 1'b1;
                bus.instr_done = bus.mem_ready;
            end
            EXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = 2'b10;
            end
            RWB: begin
                bus.reg_write  = 1'b1;
                bus.reg_dst    = 1'b1;
                bus.instr_done = 1'b1;
            end
            BEQ: begin
                bus.alu_src_a     = 1'b1;
                bus.alu_op        = 2'b01;
                bus.pc_source     = 2'b01;
                bus.pc_write_cond = 1'b1;
                bus.instr_done    = 1'b1;
            end
            JUMP: begin
                bus.pc_source  = 2'b10;
                bus.pc_write   = 1'b1;
                bus.instr_done = 1'b1;
            end
            ADDIWB: begin
                bus.reg_write  = 1'b1;
                bus.instr_done = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: doc/mc_ctrl_fsm.md
# mc_ctrl_fsm

Multicycle control state machine for the single-memory MIPS-subset datapath. Each cycle it drives the select inputs of the datapath's 2-, 3- and 4-input multiplexers, plus the register, memory and PC write enables. It sequences each instruction through fetch, decode, execute, memory and writeback. It stalls on a memory-ready handshake and reports instruction retirement and illegal opcodes.

## Interface
- STATE_W, 4, width of the state register and the `state` debug port
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- opcode  input  6  IR[31:26]; valid from DECODE onward
- zero  input  1  ALU zero flag, combinational from the datapath
- mem_ready  input  1  memory completes the current access this cycle
- pc_write  output  1  unconditional PC load
- pc_write_cond  output  1  PC load if zero=1
- i_or_d  output  1  memory address mux: 0=PC, 1=ALUOut
- mem_read  output  1  memory read strobe
- mem_write  output  1  memory write strobe
- ir_write  output  1  instruction register load
- mem_to_reg  output  1  writeback mux: 0=ALUOut, 1=MDR
- reg_dst  output  1  destination mux: 0=rt, 1=rd
- reg_write  output  1  register file write
- alu_src_a  output  1  0=PC, 1=A
- alu_src_b  output  2  00=B, 01=const 4, 10=signext(imm), 11=signext(imm)<<2
- alu_op  output  2  00=add, 01=sub, 10=decode funct
- pc_source  output  2  00=ALU result, 01=ALUOut, 10=jump target; 11 never driven
- instr_done  output  1  one-cycle pulse on an instruction's final cycle
- illegal_op  output  1  one-cycle pulse when DECODE sees an unsupported opcode
- state  output  STATE_W  current state, for debug

## Operation
- State encodings: INIT=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, RWB=8, BEQ=9, JUMP=10, ADDIEX=11, ADDIWB=12. Encodings 13–15 go to INIT on the next edge, with all outputs 0.
- Any output not listed for a state is 0.
- INIT: all outputs 0; next state FETCH.
- FETCH:
  - Outputs: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write and pc_write are 1 only when mem_ready=1.
  - Next state: DECODE if mem_ready=1, else FETCH.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Next state by opcode:
  - 100011 (lw) or 101011 (sw) → MEMADR
  - 000000 (R-type) → EXEC
  - 000100 (beq) → BEQ
  - 000010 (j) → JUMP
  - 001000 (addi) → ADDIEX
  - any other opcode → FETCH, with illegal_op=1 and instr_done=1
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next state MEMRD for lw, MEMWR for sw (opcode re-sampled).
- MEMRD: mem_read=1, i_or_d=1. Next state MEMWB on mem_ready=1, else hold.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1. Next state FETCH.
- MEMWR: mem_write=1, i_or_d=1. instr_done=mem_ready. Next state FETCH on mem_ready=1, else hold.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Next state RWB.
- RWB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1. Next state FETCH.
- BEQ: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01, pc_write_cond=1, instr_done=1. Next state FETCH. The PC load itself is gated by the datapath with zero.
- JUMP: pc_source=10, pc_write=1, instr_done=1. Next state FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00. Next state ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1. Next state FETCH.
- Stall rule: while waiting on mem_ready, all mux selects and strobes hold constant. No write enable other than the stalled memory strobe is asserted.

## Timing
- The state register updates on the rising edge of clk.
- Outputs are combinational from state. The only inputs that affect outputs are mem_ready (FETCH, MEMWR) and opcode (DECODE).
- While rst_n=0: state=INIT and every output is 0, independent of clk.
- Reset deassertion: first edge → FETCH. Reset mid-instruction (e.g. during a MEMRD stall) aborts immediately, with no partial write asserted after rst_n falls.
- Latency with mem_ready tied to 1, in cycles from FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds exactly one cycle.
- instr_done is high for exactly one cycle per instruction. The following cycle is always FETCH.
- mem_read and mem_write are never high in the same cycle.

## Test plan
- Reset then lw:
  - Stimulus: rst_n low 3 cycles, release; opcode=100011, mem_ready=1.
  - Required response: state sequence 0,1,2,3,4,5,1. instr_done high only in state 5, together with reg_write=1 and mem_to_reg=1.
- sw with wait states:
  - Stimulus: opcode=101011; mem_ready=0 for 2 cycles in MEMWR.
  - Required response: MEMWR lasts 3 cycles with mem_write=1 and i_or_d=1 throughout; instr_done only in the last of those cycles.
- FETCH stall:
  - Stimulus: mem_ready=0 for 4 cycles in FETCH.
  - Required response: ir_write=0 and pc_write=0 for those 4 cycles; both 1 in the 5th cycle, which advances to DECODE.
- beq and j:
  - beq (000100): state 9 drives alu_op=01, pc_source=01, pc_write_cond=1.
  - j (000010): state 10 drives pc_source=10, pc_write=1.
  - Each takes 3 cycles.
- Illegal opcode:
  - Stimulus: opcode=111111 in DECODE.
  - Required response: illegal_op=1 and instr_done=1 for one cycle, then FETCH; no reg_write or mem_write asserted.
- Async reset mid-MEMRD:
  - Stimulus: drop rst_n between clock edges while in MEMRD.
  - Required response: state=0 and all outputs 0 before the next edge; after release, FETCH is entered on the first edge.
